sd_spi_master: RTL and testbench



---
 rtl/sd_spi_master.sv | 173 +++++++++++++++++
 tb/tb_sd_spi_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte engine for the SD slot: shifts sd_datain out MSB-first on sddo,
// captures sddi on each sdclk rise and queues at most one byte behind the active one.
module sd_spi_master #(
  parameter int HALF_DIV = 2
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       sd_start,
  input  logic [7:0] sd_datain,
  output logic [7:0] sd_dataout,
  output logic       sdclk,
  output logic       sddo,
  input  logic       sddi,
  output logic       busy,
  output logic       sd_ovr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LOAD = 8'(HALF_DIV - 1);

  state_t     state_r, state_s;
  logic [7:0] tx_r, tx_s;
  logic [7:0] rx_r, rx_s;
  logic [2:0] bitcnt_r, bitcnt_s;
  logic [7:0] divcnt_r, divcnt_s;
  logic [7:0] pend_r, pend_s;
  logic       pend_v_r, pend_v_s;
  logic [7:0] dout_r, dout_s;
  logic       sdclk_r, sdclk_s;
  logic       sddo_r, sddo_s;
  logic       busy_r, busy_s;
  logic       ovr_r, ovr_s;
  logic       done_s;
  logic       load_s;
  logic [7:0] load_byte_s;
  logic       div_zero_s;

  // Next-state and next-output logic for the shift FSM and the pending buffer
  always_comb begin
    state_s     = state_r;
    tx_s        = tx_r;
    rx_s        = rx_r;
    bitcnt_s    = bitcnt_r;
    divcnt_s    = divcnt_r;
    pend_s      = pend_r;
    pend_v_s    = pend_v_r;
    dout_s      = dout_r;
    sdclk_s     = sdclk_r;
    sddo_s      = sddo_r;
    ovr_s       = ovr_r;
    done_s      = 1'b0;
    load_s      = 1'b0;
    load_byte_s = sd_datain;
    div_zero_s  = (divcnt_r == 8'd0);

    case (state_r)
      ST_IDLE: begin
        if (sd_start) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_LOW: begin
        if (div_zero_s) begin
          sdclk_s  = 1'b1;
          rx_s     = {rx_r[6:0], sddi};
          divcnt_s = DIV_LOAD;
          state_s  = ST_HIGH;
        end else begin
          divcnt_s = divcnt_r - 8'd1;
        end
      end
      ST_HIGH: begin
        if (div_zero_s) begin
          sdclk_s  = 1'b0;
          divcnt_s = DIV_LOAD;
          if (bitcnt_r != 3'd0) begin
            tx_s     = {tx_r[6:0], 1'b1};
            sddo_s   = tx_r[6];
            bitcnt_s = bitcnt_r - 3'd1;
            state_s  = ST_LOW;
          end else begin
            done_s = 1'b1;
            dout_s = rx_r;
            // A queued byte (or a start landing on this edge) continues with no idle gap
            if (pend_v_r) begin
              load_s      = 1'b1;
              load_byte_s = pend_r;
              pend_v_s    = 1'b0;
            end else if (sd_start) begin
              load_s = 1'b1;
            end else begin
              sddo_s  = 1'b1;
              state_s = ST_IDLE;
            end
          end
        end else begin
          divcnt_s = divcnt_r - 8'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        sdclk_s = 1'b0;
        sddo_s  = 1'b1;
      end
    endcase

    if (load_s) begin
      tx_s     = load_byte_s;
      sddo_s   = load_byte_s[7];
      bitcnt_s = 3'd7;
      divcnt_s = DIV_LOAD;
      state_s  = ST_LOW;
    end else begin
      tx_s = tx_s;
    end

    // Start while shifting goes to the pending slot; a second one overwrites it and flags overrun
    if (sd_start && (state_r != ST_IDLE) && !(done_s && !pend_v_r)) begin
      pend_s   = sd_datain;
      pend_v_s = 1'b1;
      ovr_s    = ovr_r | (pend_v_r & ~done_s);
    end else begin
      ovr_s = ovr_s;
    end

    busy_s = (state_s != ST_IDLE) || (state_r != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      tx_r     <= 8'hFF;
      rx_r     <= 8'hFF;
      bitcnt_r <= 3'd0;
      divcnt_r <= 8'd0;
      pend_r   <= 8'h00;
      pend_v_r <= 1'b0;
      dout_r   <= 8'hFF;
      sdclk_r  <= 1'b0;
      sddo_r   <= 1'b1;
      busy_r   <= 1'b0;
      ovr_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      tx_r     <= tx_s;
      rx_r     <= rx_s;
      bitcnt_r <= bitcnt_s;
      divcnt_r <= divcnt_s;
      pend_r   <= pend_s;
      pend_v_r <= pend_v_s;
      dout_r   <= dout_s;
      sdclk_r  <= sdclk_s;
      sddo_r   <= sddo_s;
      busy_r   <= busy_s;
      ovr_r    <= ovr_s;
    end
  end

  assign sd_dataout = dout_r;
  assign sdclk      = sdclk_r;
  assign sddo       = sddo_r;
  assign busy       = busy_r;
  assign sd_ovr     = ovr_r;

endmodule

// File: tb/tb_sd_spi_master.sv
// Bench for sd_spi_master: two instances (HALF_DIV 2 and 1) checked every cycle against
// a byte-level timing model that predicts the SPI waveform from start/completion cycle numbers.
module tb_sd_spi_master;

  logic       fclk = 1'b0;
  logic       rst;
  logic       sd_start   [2];
  logic [7:0] sd_datain  [2];
  logic [7:0] sd_dataout [2];
  logic       sdclk      [2];
  logic       sddo       [2];
  logic       sddi       [2];
  logic       busy       [2];
  logic       sd_ovr     [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // model state, per instance
  bit         m_act  [2];
  int         m_s    [2];
  logic [7:0] m_byte [2];
  logic [7:0] m_card [2];
  logic [7:0] m_next_card [2];
  logic [7:0] m_pend [2];
  bit         m_pv   [2];
  bit         m_ovr  [2];
  bit         m_busy [2];
  logic [7:0] m_dout [2];

  always #5 fclk = ~fclk;

  sd_spi_master #(.HALF_DIV(2)) u_div2 (
    .fclk(fclk), .rst(rst), .sd_start(sd_start[0]), .sd_datain(sd_datain[0]),
    .sd_dataout(sd_dataout[0]), .sdclk(sdclk[0]), .sddo(sddo[0]), .sddi(sddi[0]),
    .busy(busy[0]), .sd_ovr(sd_ovr[0])
  );

  sd_spi_master #(.HALF_DIV(1)) u_div1 (
    .fclk(fclk), .rst(rst), .sd_start(sd_start[1]), .sd_datain(sd_datain[1]),
    .sd_dataout(sd_dataout[1]), .sdclk(sdclk[1]), .sddo(sddo[1]), .sddi(sddi[1]),
    .busy(busy[1]), .sd_ovr(sd_ovr[1])
  );

  function automatic int hd(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic m_reset(input int i);
    m_act[i]  = 1'b0;
    m_pv[i]   = 1'b0;
    m_ovr[i]  = 1'b0;
    m_busy[i] = 1'b0;
    m_dout[i] = 8'hFF;
  endtask

  task automatic m_begin(input int i, input logic [7:0] b, input int c);
    m_act[i]  = 1'b1;
    m_s[i]    = c;
    m_byte[i] = b;
    m_card[i] = m_next_card[i];
    m_next_card[i] = 8'($urandom);
  endtask

  // one fclk cycle c of the byte-level model; a byte started in cycle s completes in s+16*H
  task automatic m_step(input int i, input int c);
    bit was;
    was = m_act[i];
    if (m_act[i] && (c == m_s[i] + 16 * hd(i))) begin
      m_dout[i] = m_card[i];
      if (m_pv[i]) begin
        m_begin(i, m_pend[i], c);
        m_pv[i] = 1'b0;
        if (sd_start[i]) begin
          m_pend[i] = sd_datain[i];
          m_pv[i]   = 1'b1;
        end
      end else if (sd_start[i]) begin
        m_begin(i, sd_datain[i], c);
      end else begin
        m_act[i] = 1'b0;
      end
    end else if (m_act[i]) begin
      if (sd_start[i]) begin
        if (m_pv[i]) m_ovr[i] = 1'b1;
        m_pend[i] = sd_datain[i];
        m_pv[i]   = 1'b1;
      end
    end else if (sd_start[i]) begin
      m_begin(i, sd_datain[i], c);
    end
    m_busy[i] = was || m_act[i];
  endtask

  task automatic tick();
    @(posedge fclk);
    for (int i = 0; i < 2; i++) begin
      if (rst) m_reset(i);
      else m_step(i, cyc);
    end
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      int  o;
      int  h;
      bit  ck;
      bit  db;
      h = hd(i);
      if (m_act[i]) begin
        o  = cyc - (m_s[i] + 1);
        ck = ((o / h) % 2) == 1;
        db = m_byte[i][7 - o / (2 * h)];
        sddi[i] = m_card[i][7 - o / (2 * h)];
      end else begin
        ck = 1'b0;
        db = 1'b1;
        sddi[i] = 1'b1;
      end
      check_val($sformatf("u%0d sdclk", i), 8'(sdclk[i]), 8'(ck));
      check_val($sformatf("u%0d sddo", i), 8'(sddo[i]), 8'(db));
      check_val($sformatf("u%0d busy", i), 8'(busy[i]), 8'(m_busy[i]));
      check_val($sformatf("u%0d ovr", i), 8'(sd_ovr[i]), 8'(m_ovr[i]));
      check_val($sformatf("u%0d dout", i), sd_dataout[i], m_dout[i]);
    end
    sd_start[0] = 1'b0;
    sd_start[1] = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic start(input int i, input logic [7:0] b);
    sd_start[i]  = 1'b1;
    sd_datain[i] = b;
    tick();
  endtask

  // assert rst between edges and check outputs before the next edge
  task automatic async_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      m_reset(i);
      sddi[i] = 1'b1;
      check_val($sformatf("u%0d rst sdclk", i), 8'(sdclk[i]), 8'h00);
      check_val($sformatf("u%0d rst sddo", i), 8'(sddo[i]), 8'h01);
      check_val($sformatf("u%0d rst busy", i), 8'(busy[i]), 8'h00);
      check_val($sformatf("u%0d rst dout", i), sd_dataout[i], 8'hFF);
      check_val($sformatf("u%0d rst ovr", i), 8'(sd_ovr[i]), 8'h00);
    end
    ticks(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sd_start[i]  = 1'b0;
      sd_datain[i] = 8'h00;
      sddi[i]      = 1'b1;
      m_next_card[i] = 8'($urandom);
      m_reset(i);
    end
    ticks(3);
    rst = 1'b0;
    ticks(2);

    // single byte A5 out, 3C back
    m_next_card[0] = 8'h3C;
    start(0, 8'hA5);
    ticks(31);
    check_val("a5 dout before done", sd_dataout[0], 8'hFF);
    tick();
    check_val("a5 dout at t+33", sd_dataout[0], 8'h3C);
    check_val("a5 busy at t+33", 8'(busy[0]), 8'h01);
    tick();
    check_val("a5 busy at t+34", 8'(busy[0]), 8'h00);
    check_val("a5 sddo idle", 8'(sddo[0]), 8'h01);
    ticks(4);

    // one pending byte, back-to-back
    m_next_card[0] = 8'h81;
    start(0, 8'hC3);
    m_next_card[0] = 8'h7E;
    ticks(5);
    start(0, 8'h12);
    ticks(26);
    check_val("two dout byte1", sd_dataout[0], 8'h81);
    check_val("two busy mid", 8'(busy[0]), 8'h01);
    ticks(32);
    check_val("two dout byte2", sd_dataout[0], 8'h7E);
    tick();
    check_val("two busy end", 8'(busy[0]), 8'h00);
    check_val("two ovr", 8'(sd_ovr[0]), 8'h00);
    ticks(3);

    // overrun: 22 replaced by 33
    start(0, 8'h11);
    ticks(3);
    start(0, 8'h22);
    ticks(3);
    start(0, 8'h33);
    check_val("ovr set", 8'(sd_ovr[0]), 8'h01);
    ticks(70);

    // reset in the middle of bit 4
    start(0, 8'h96);
    ticks(13);
    check_val("ovr sticky", 8'(sd_ovr[0]), 8'h01);
    async_reset();
    ticks(2);
    m_next_card[0] = 8'hC9;
    start(0, 8'h5A);
    ticks(40);
    check_val("5a dout", sd_dataout[0], 8'hC9);
    check_val("5a busy", 8'(busy[0]), 8'h00);

    // HALF_DIV=1 read: clear dout to 00 first, then FF with sddi high
    m_next_card[1] = 8'h00;
    start(1, 8'h00);
    ticks(20);
    m_next_card[1] = 8'hFF;
    start(1, 8'hFF);
    ticks(15);
    check_val("div1 dout before", sd_dataout[1], 8'h00);
    tick();
    check_val("div1 dout t+17", sd_dataout[1], 8'hFF);
    check_val("div1 busy t+17", 8'(busy[1]), 8'h01);
    tick();
    check_val("div1 busy t+18", 8'(busy[1]), 8'h00);

    // start coincident with the completion edge
    m_next_card[0] = 8'h24;
    start(0, 8'h0F);
    ticks(31);
    start(0, 8'hF0);
    check_val("coin dout", sd_dataout[0], 8'h24);
    check_val("coin busy", 8'(busy[0]), 8'h01);
    ticks(40);
    check_val("coin ovr", 8'(sd_ovr[0]), 8'h00);

    // random traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        sd_start[i]  = ($urandom_range(0, 24) == 0);
        sd_datain[i] = 8'($urandom);
      end
      tick();
    end
    ticks(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
